// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle FETCH/EXEC/MEM/HALT control sequencer for the 16-bit datapath.
// Optional retired-instruction counter is built only when CPU_CTRL_PERF_EN is defined.
module cpu_ctrl_seq #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int FS_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       ir,
    input  logic              mem_ready,
    input  logic              z,
    output logic              ir_load,
    output logic [1:0]        pc_sel,
    output logic [DATA_W-1:0] pc_offset,
    output logic [REG_AW-1:0] aa,
    output logic [REG_AW-1:0] ba,
    output logic [REG_AW-1:0] da,
    output logic              wr,
    output logic [FS_W-1:0]   fs,
    output logic              mux_b,
    output logic [DATA_W-1:0] k,
    output logic              mux_d,
    output logic              addr_sel,
    output logic              mem_read,
    output logic              mem_write,
    output logic              halted,
    output logic [31:0]       instr_count
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic signed [8:0] offset_raw;

    assign offset_raw = ir[8:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_nxt;
    end

    // Every control output is gated by reset_n so an access aborts without waiting for a clock.
    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        pc_sel    = 2'b00;
        pc_offset = '0;
        aa        = '0;
        ba        = '0;
        da        = '0;
        wr        = 1'b0;
        fs        = '0;
        mux_b     = 1'b0;
        k         = '0;
        mux_d     = 1'b0;
        addr_sel  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        halted    = 1'b0;
        if (reset_n) begin
            unique case (state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_load   = 1'b1;
                        pc_sel    = 2'b01;
                        state_nxt = S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_nxt = S_FETCH;
                    unique case (ir[15:14])
                        2'b00, 2'b01: begin
                            da    = REG_AW'(ir[8:6]);
                            aa    = REG_AW'(ir[5:3]);
                            ba    = REG_AW'(ir[2:0]);
                            fs    = FS_W'(ir[13:9]);
                            wr    = 1'b1;
                            mux_b = ir[14];
                            if (ir[14]) k = DATA_W'(ir[2:0]);
                        end
                        2'b10: begin
                            da        = REG_AW'(ir[8:6]);
                            aa        = REG_AW'(ir[5:3]);
                            ba        = REG_AW'(ir[2:0]);
                            state_nxt = S_MEM;
                        end
                        default: begin
                            unique case (ir[13:12])
                                2'b00: begin
                                    pc_offset = DATA_W'(offset_raw);
                                    pc_sel    = z ? 2'b10 : 2'b00;
                                end
                                2'b01: begin
                                    aa     = REG_AW'(ir[5:3]);
                                    pc_sel = 2'b11;
                                end
                                2'b11:   state_nxt = S_HALT;
                                default: ;
                            endcase
                        end
                    endcase
                end
                S_MEM: begin
                    // Address and register fields stay on the bus for the whole access.
                    da       = REG_AW'(ir[8:6]);
                    aa       = REG_AW'(ir[5:3]);
                    ba       = REG_AW'(ir[2:0]);
                    addr_sel = 1'b1;
                    if (!ir[13]) begin
                        mem_read = 1'b1;
                        mux_d    = 1'b1;
                        wr       = mem_ready;
                    end else begin
                        mem_write = 1'b1;
                    end
                    if (mem_ready) state_nxt = S_FETCH;
                end
                default: halted = 1'b1;
            endcase
        end
    end

`ifdef CPU_CTRL_PERF_EN
    logic        retire;
    logic [31:0] count;

    // Reserved opcodes in EXEC still retire; only memory ops defer to MEM.
    assign retire = ((state == S_EXEC) && (ir[15:14] != 2'b10)) ||
                    ((state == S_MEM) && mem_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    count <= '0;
        else if (retire) count <= count + 32'd1;
    end

    assign instr_count = count;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: walks ALU, immediate, load, branch, jump, store-abort,
// reserved and halt instructions with hand-computed control words.
module tb_cpu_ctrl_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] ir;
    logic        mem_ready;
    logic        z;
    logic        ir_load;
    logic [1:0]  pc_sel;
    logic [15:0] pc_offset;
    logic [2:0]  aa, ba, da;
    logic        wr;
    logic [4:0]  fs;
    logic        mux_b;
    logic [15:0] k;
    logic        mux_d;
    logic        addr_sel;
    logic        mem_read, mem_write;
    logic        halted;
    logic [31:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

`ifdef CPU_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    cpu_ctrl_seq #(.DATA_W(16), .REG_AW(3), .FS_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .ir(ir), .mem_ready(mem_ready), .z(z),
        .ir_load(ir_load), .pc_sel(pc_sel), .pc_offset(pc_offset),
        .aa(aa), .ba(ba), .da(da), .wr(wr), .fs(fs), .mux_b(mux_b), .k(k),
        .mux_d(mux_d), .addr_sel(addr_sel), .mem_read(mem_read),
        .mem_write(mem_write), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    initial begin
        reset_n = 1'b0; ir = 16'h0000; mem_ready = 1'b0; z = 1'b0;
        #1;
        chk("rst_mem_read", 32'(mem_read), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_count", instr_count, 0);
        tick(); tick();
        reset_n = 1'b1;
        #1;
        chk("fetch_mem_read", 32'(mem_read), 1);
        chk("fetch_wait_ir_load", 32'(ir_load), 0);
        chk("fetch_wait_pc_sel", 32'(pc_sel), 0);

        // ALU-reg 0A53: da=1 aa=2 ba=3 fs=5
        tick();
        ir = 16'h0A53; mem_ready = 1'b1;
        #1;
        chk("fetch_ir_load", 32'(ir_load), 1);
        chk("fetch_pc_sel", 32'(pc_sel), 1);
        chk("fetch_addr_sel", 32'(addr_sel), 0);
        tick(); #1;
        chk("alu_wr", 32'(wr), 1);
        chk("alu_da", 32'(da), 1);
        chk("alu_aa", 32'(aa), 2);
        chk("alu_ba", 32'(ba), 3);
        chk("alu_fs", 32'(fs), 5);
        chk("alu_mux_b", 32'(mux_b), 0);
        chk("alu_mem_read", 32'(mem_read), 0);

        // ALU-imm 4A53: k=3, mux_b=1
        tick();
        ir = 16'h4A53;
        #1;
        chk("fetch2_ir_load", 32'(ir_load), 1);
        chk("fetch_count1", instr_count, cnt(1));
        tick(); #1;
        chk("imm_mux_b", 32'(mux_b), 1);
        chk("imm_k", 32'(k), 3);
        chk("imm_wr", 32'(wr), 1);
        chk("imm_fs", 32'(fs), 5);

        // Load 8053 with three wait states in MEM
        tick();
        ir = 16'h8053;
        tick();
        mem_ready = 1'b0;
        #1;
        chk("ld_exec_aa", 32'(aa), 2);
        chk("ld_exec_wr", 32'(wr), 0);
        chk("ld_exec_mem_read", 32'(mem_read), 0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("ld_wait_mem_read", 32'(mem_read), 1);
            chk("ld_wait_addr_sel", 32'(addr_sel), 1);
            chk("ld_wait_mux_d", 32'(mux_d), 1);
            chk("ld_wait_wr", 32'(wr), 0);
            chk("ld_wait_pc_sel", 32'(pc_sel), 0);
            chk("ld_wait_ir_load", 32'(ir_load), 0);
            chk("ld_wait_da", 32'(da), 1);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        chk("ld_done_wr", 32'(wr), 1);
        chk("ld_done_mem_read", 32'(mem_read), 1);
        chk("ld_done_addr_sel", 32'(addr_sel), 1);
        tick(); #1;
        chk("ld_back_fetch_addr_sel", 32'(addr_sel), 0);
        chk("ld_back_fetch_mux_d", 32'(mux_d), 0);
        chk("ld_back_fetch_ir_load", 32'(ir_load), 1);
        chk("ld_count3", instr_count, cnt(3));

        // BRZ C1FF: offset -1
        ir = 16'hC1FF; z = 1'b1;
        tick(); #1;
        chk("brz_pc_sel_z1", 32'(pc_sel), 2);
        chk("brz_pc_offset", 32'(pc_offset), 32'h0000_FFFF);
        z = 1'b0;
        #1;
        chk("brz_pc_sel_z0", 32'(pc_sel), 0);
        chk("brz_wr", 32'(wr), 0);

        // JMP D028: aa=5
        tick();
        ir = 16'hD028;
        tick(); #1;
        chk("jmp_pc_sel", 32'(pc_sel), 3);
        chk("jmp_aa", 32'(aa), 5);
        chk("jmp_wr", 32'(wr), 0);

        // Store A053, reset pulsed in the middle of the MEM wait
        tick();
        ir = 16'hA053;
        tick();
        mem_ready = 1'b0;
        #1;
        chk("st_exec_count5", instr_count, cnt(5));
        tick(); #1;
        chk("st_mem_write", 32'(mem_write), 1);
        chk("st_addr_sel", 32'(addr_sel), 1);
        chk("st_mem_read", 32'(mem_read), 0);
        chk("st_wr", 32'(wr), 0);
        reset_n = 1'b0;
        #1;
        chk("st_abort_mem_write", 32'(mem_write), 0);
        chk("st_abort_addr_sel", 32'(addr_sel), 0);
        chk("st_abort_count", instr_count, 0);
        #1;
        reset_n = 1'b1;
        #1;
        chk("st_after_rst_mem_read", 32'(mem_read), 1);
        chk("st_after_rst_mem_write", 32'(mem_write), 0);

        // Reserved E000 acts as NOP
        tick();
        mem_ready = 1'b1; ir = 16'hE000;
        tick(); #1;
        chk("nop_pc_sel", 32'(pc_sel), 0);
        chk("nop_wr", 32'(wr), 0);
        chk("nop_mem_read", 32'(mem_read), 0);

        // HALT F000
        tick();
        ir = 16'hF000;
        tick(); #1;
        chk("halt_exec_halted", 32'(halted), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            mem_ready = i[0];
            #1;
            chk("halt_halted", 32'(halted), 1);
            chk("halt_mem_read", 32'(mem_read), 0);
            chk("halt_ir_load", 32'(ir_load), 0);
            chk("halt_pc_sel", 32'(pc_sel), 0);
        end
        chk("halt_count", instr_count, cnt(2));
        reset_n = 1'b0;
        #1;
        chk("halt_rst_halted", 32'(halted), 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("halt_exit_mem_read", 32'(mem_read), 1);
        chk("halt_exit_halted", 32'(halted), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_seq.md
# cpu_ctrl_seq

Multi-cycle control sequencer for the 16-bit datapath. It replaces the single-cycle instruction decoder with a state machine. The block fetches through a memory handshake, decodes the instruction register, and drives the per-cycle control word: register addresses, function select, muxes, PC select and memory strobes. ALU, immediate, load/store, branch, jump and halt classes are supported. Widths are parametrised for wider datapath and register-file generations.

## Interface
- DATA_W, 16, datapath width; width of `k` and `pc_offset`
- REG_AW, 3, register-file address width; `aa`/`ba`/`da` width
- FS_W, 5, ALU function-select width
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- ir  in  16  instruction register contents (datapath-held)
- mem_ready  in  1  memory completes current read/write this cycle
- z  in  1  datapath zero flag
- ir_load  out  1  load IR from memory data this cycle
- pc_sel  out  2  00 hold, 01 PC+1, 10 PC+pc_offset, 11 PC←R[aa]
- pc_offset  out  DATA_W  sign-extended ir[8:0]
- aa, ba, da  out  REG_AW  A, B and destination addresses (zero-extended ir fields)
- wr  out  1  register-file write enable
- fs  out  FS_W  ALU function (ir[13:9], zero-extended)
- mux_b  out  1  0 = R[ba], 1 = `k`
- k  out  DATA_W  zero-extended ir[2:0]
- mux_d  out  1  0 = ALU result, 1 = memory data
- addr_sel  out  1  memory address: 0 = PC, 1 = R[aa]
- mem_read, mem_write  out  1  memory strobes
- halted  out  1  high in HALT
- instr_count  out  32  retired instructions (see Configuration)

## Operation
- States: FETCH, EXEC, MEM, HALT. The state register is the only sequential element besides `instr_count`. Outputs decode combinationally from state, `ir`, `mem_ready` and `z`.
- Outputs not named for a state are 0.
- FETCH:
  - Drive `mem_read`=1, `addr_sel`=0.
  - If `mem_ready`: `ir_load`=1, `pc_sel`=01, go to EXEC. Otherwise stay in FETCH.
- EXEC decodes `ir[15:14]`:
  - 00 ALU-reg: `da`=ir[8:6], `aa`=ir[5:3], `ba`=ir[2:0], `fs`=ir[13:9], `wr`=1, `mux_b`=0. Retire and go to FETCH.
  - 01 ALU-imm: as ALU-reg with `mux_b`=1 and `k`=ir[2:0]. Retire and go to FETCH.
  - 10 memory: `aa`=ir[5:3], `ba`=ir[2:0], `da`=ir[8:6]. Go to MEM.
  - 11, ir[13:12]=00 BRZ: `pc_sel`=10 if `z`, else 00. Retire and go to FETCH.
  - 11, ir[13:12]=01 JMP: `aa`=ir[5:3], `pc_sel`=11. Retire and go to FETCH.
  - 11, ir[13:12]=11 HALT: retire and go to HALT.
  - 11, ir[13:12]=10 (reserved): NOP. Retire and go to FETCH.
- MEM, ir[13]=0 (load): `mem_read`=1, `addr_sel`=1, `mux_d`=1. `wr`=1 only in the cycle `mem_ready`=1; that cycle retires and goes to FETCH.
- MEM, ir[13]=1 (store): `mem_write`=1, `addr_sel`=1, `wr`=0. Hold until `mem_ready`, then retire and go to FETCH.
- HALT: all strobes 0, `halted`=1, `pc_sel`=00. Only reset exits HALT.

## Timing
- Reset (async assert, sync release): state=FETCH, `instr_count`=0. While `reset_n`=0, every control output is forced to 0, including `mem_read`.
- First cycle after release: FETCH with `mem_read`=1.
- Latency with `mem_ready` always 1:
  - ALU, branch, jump: 2 cycles.
  - Load/store: 3 cycles.
  - HALT: 2 cycles to assert `halted`.
- Each wait-state cycle of `mem_ready`=0 adds exactly one cycle. During a wait, the control word is held stable and `wr`, `ir_load` and `pc_sel` stay 0/00.
- `mem_ready` is ignored in EXEC and HALT.
- Reset mid-MEM aborts the access immediately: strobes drop asynchronously and no write-back occurs.
- `pc_offset` is sign-extended ir[8:0]: ir[8:0]=9'h1FF gives -1. Wrap-around belongs to the PC adder.

## Configuration
- CPU_CTRL_PERF_EN defined:
  - `instr_count` increments by 1 in every retire cycle.
  - It wraps 0xFFFFFFFF→0.
  - It holds in HALT.
- CPU_CTRL_PERF_EN undefined: no counter flops exist and `instr_count` is tied to 0.

## Test plan
- Reset, then `mem_ready`=1, ir=16'h0A53 (ALU-reg) -> FETCH `ir_load`=1/`pc_sel`=01; next cycle `wr`=1, `da`=1, `aa`=2, `ba`=3, `fs`=5'h05, `mux_b`=0.
- ir=16'h8053 (load), `mem_ready` low 3 cycles in MEM -> `mem_read`/`addr_sel`=1 held 4 cycles, `wr`=1 only in the 4th, then FETCH.
- BRZ ir=16'hC1FF with z=1 -> `pc_sel`=10, `pc_offset`=16'hFFFF; with z=0 -> `pc_sel`=00.
- HALT ir=16'hF000 -> `halted`=1 from the cycle after EXEC, outputs frozen for 20 cycles; `reset_n` low returns to FETCH.
- `reset_n` pulsed low mid-store -> `mem_write` falls the same cycle without waiting for a clock edge; `instr_count`=0.
- With CPU_CTRL_PERF_EN, 5 ALU instructions -> `instr_count`=5; without it -> `instr_count`=0 throughout.
